multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, and the IR, A/B, ALUOut and MDR registers.
- Instruction set: R-type add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq, bne, j.
- Takes opcode/funct from the IR and drives every datapath select and enable, state by state.
- Handshakes with memory through mem_ready, with an optional timeout.

Parameters:
- WAIT_LIMIT, default 0: maximum cycles to wait for mem_ready in one memory state. 0 disables the timeout.
- CNT_W, default 8: width of the wait counter. Requires WAIT_LIMIT < 2**CNT_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next fetch completes.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory has completed the current read or write in this cycle.
- pc_write  out  1  unconditional PC load.
- branch_eq  out  1  PC load if ALU zero.
- branch_ne  out  1  PC load if ALU not zero.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], IR[25:0], 2'b00}.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_dst  out  1  register write address: 1 rd, 0 rt.
- mem_to_reg  out  1  register write data: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 PC, 1 A.
- alu_src_b  out  2  ALU B input: 00 B, 01 const 4, 10 ext imm, 11 sext imm<<2.
- imm_zext  out  1  immediate extension: 1 zero-extend, 0 sign-extend.
- alu_control  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct.
- bus_error  out  1  one-cycle pulse on mem_ready timeout.
- state  out  4  current state, for debug.

Behaviour:
- States, encoded 0 to 12 in this order: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, ILLEGAL.
- Unless a state lists otherwise, every output is 0 and alu_control is 0010.
- Reset: a clock edge with rst_n=0 sets state=FETCH and clears the wait counter. While rst_n=0, every strobe and enable output is forced to 0. Reset mid-instruction abandons that instruction with no write.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - ir_write and pc_write are asserted only in a cycle where mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (branch target into ALUOut).
  - Next state by opcode: 000000 with legal funct (32, 34, 36, 37, 42) -> EXEC_R; 8/12/13/10 -> EXEC_I; 35/43 -> MEMADR; 4/5 -> BRANCH; 2 -> JUMP; anything else -> ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEMWR: mem_write=1, iord=1, held for the whole wait. On mem_ready: instr_done=1 and -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_control from funct: add 0010, sub 0110, and 0000, or 0001, slt 0111. Next: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. addi 0010, andi 0000 with imm_zext=1, ori 0001 with imm_zext=1, slti 0111. Next: IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. branch_eq=1 for beq, branch_ne=1 for bne. instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Next: FETCH.
- ILLEGAL: illegal_op=1, no writes, no instr_done. PC has already advanced past the instruction. Next: FETCH.
- Latency in cycles with zero memory wait: lw 5, sw 4, R-type 4, I-type 4, branch 3, jump 3. Each wait cycle adds 1.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on every state change.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with mem_ready still 0: bus_error=1 for that cycle, no ir/pc/reg write, next state FETCH (a fetch timeout retries the same PC).
  - mem_ready=1 in the limit cycle completes the access normally with no error.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Test Plan:
- Reset: rst_n=0 for 2 cycles in the middle of MEMWR (mem_write=1) -> mem_write drops to 0 in the reset cycle; state=0 after the edge; all strobes 0.
- add ($3,$1,$2), mem_ready=1 -> state sequence 0,1,6,7,0; alu_control=0010 in EXEC_R; reg_write=1 and reg_dst=1 in RWB; instr_done pulses once.
- lw 0x8C220020 with mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; mem_read=1 and iord=1 held throughout MEMRD; mem_to_reg=1 in MEMWB.
- beq, then bne, then j (0x08002710) -> BRANCH has pc_src=01 and alu_control=0110, with branch_eq then branch_ne set; JUMP has pc_write=1 and pc_src=10; each completes in 3 cycles.
- opcode 6'b111111, then R-type funct 6'b000000 -> each goes 0,1,12,0 with a single illegal_op pulse and no reg_write or mem_write.
- WAIT_LIMIT=3, mem_ready held at 0 in FETCH -> bus_error pulses at the 3rd wait cycle; ir_write never asserted; FETCH re-enters. mem_ready=1 exactly in the limit cycle -> no bus_error and the FSM proceeds to DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style sequencer for a shared multicycle MIPS datapath
//                (single memory port, single ALU, IR/A/B/ALUOut/MDR). Decodes
//                opcode/funct and drives every datapath select and enable
//                state by state, with a mem_ready handshake and an optional
//                memory wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch_eq,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state
);

    // State encoding, 0..12 in sequencing order
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_IWB     = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALU operations
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // The timeout fires in the WAIT_LIMIT-th consecutive wait cycle, i.e. when
    // WAIT_LIMIT-1 earlier wait cycles have already been counted.
    localparam bit              TIMEOUT_EN = (WAIT_LIMIT > 0);
    localparam logic [CNT_W-1:0] LAST_WAIT =
        TIMEOUT_EN ? CNT_W'(WAIT_LIMIT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_r_legal;
    logic [3:0]       w_r_alu;

    assign state = r_state;

    // Only these states hold the memory port and honour mem_ready
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);

    assign w_timeout = TIMEOUT_EN && w_mem_state && !mem_ready &&
                       (r_wait_cnt == LAST_WAIT);

    // Decode the R-type function field into legality and ALU operation
    always_comb begin
        w_r_legal = 1'b1;
        w_r_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  w_r_alu = ALU_ADD;
            FN_SUB:  w_r_alu = ALU_SUB;
            FN_AND:  w_r_alu = ALU_AND;
            FN_OR:   w_r_alu = ALU_OR;
            FN_SLT:  w_r_alu = ALU_SLT;
            default: w_r_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Wait counter: counts memory-state cycles without mem_ready, otherwise
    // clears (every state change happens on mem_ready, timeout or a
    // non-memory state, so this also clears it on state changes)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !mem_ready && !w_timeout) begin
            if (r_wait_cnt != CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: w_next_state = w_r_legal ? S_EXEC_R : S_ILLEGAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:
                              w_next_state = S_EXEC_I;
                    OP_LW, OP_SW:
                              w_next_state = S_MEMADR;
                    OP_BEQ, OP_BNE:
                              w_next_state = S_BRANCH;
                    OP_J:     w_next_state = S_JUMP;
                    default:  w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      w_next_state = S_MEMWB;
                else if (w_timeout) w_next_state = S_FETCH;
                else                w_next_state = S_MEMRD;
            end
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = (mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
            S_EXEC_R: w_next_state = S_RWB;
            S_RWB:    w_next_state = S_FETCH;
            S_EXEC_I: w_next_state = S_IWB;
            S_IWB:    w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
            S_ILLEGAL: w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Output decode per state; strobes and enables are forced low in reset
    always_comb begin
        pc_write    = 1'b0;
        branch_eq   = 1'b0;
        branch_ne   = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_zext    = 1'b0;
        alu_control = ALU_ADD;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = w_timeout;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC load only in the cycle the read completes
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = w_r_alu;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        imm_zext    = 1'b1;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        imm_zext    = 1'b1;
                    end
                    OP_SLTI: alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch_eq   = (opcode == OP_BEQ);
                branch_ne   = (opcode == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
                illegal_op = 1'b0;
            end
        endcase
        if (!rst_n) begin
            pc_write   = 1'b0;
            branch_eq  = 1'b0;
            branch_ne  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            bus_error  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed, table-driven bench for multicycle_control
//                (WAIT_LIMIT=3) plus hand sequences for reset and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, branch_eq, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zext;
    logic       instr_done, illegal_op, bus_error;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_control, state;

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write), .branch_eq(branch_eq),
        .branch_ne(branch_ne), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .alu_control(alu_control), .instr_done(instr_done),
        .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
    );

    // Control word layout used by expected values
    logic [22:0] act_ctl;
    assign act_ctl = {pc_write, branch_eq, branch_ne, pc_src, iord, mem_read,
                      mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                      alu_src_a, alu_src_b, imm_zext, alu_control, instr_done,
                      illegal_op, bus_error};

    localparam logic [22:0] PCW  = 23'(1) << 22;
    localparam logic [22:0] BEQ  = 23'(1) << 21;
    localparam logic [22:0] BNE  = 23'(1) << 20;
    localparam logic [22:0] IORD = 23'(1) << 17;
    localparam logic [22:0] MR   = 23'(1) << 16;
    localparam logic [22:0] MW   = 23'(1) << 15;
    localparam logic [22:0] IRW  = 23'(1) << 14;
    localparam logic [22:0] RDST = 23'(1) << 13;
    localparam logic [22:0] M2R  = 23'(1) << 12;
    localparam logic [22:0] RW   = 23'(1) << 11;
    localparam logic [22:0] ASA  = 23'(1) << 10;
    localparam logic [22:0] ZEXT = 23'(1) << 7;
    localparam logic [22:0] DONE = 23'(1) << 2;
    localparam logic [22:0] ILL  = 23'(1) << 1;
    localparam logic [22:0] BERR = 23'(1);

    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001, A_SLT = 4'b0111;

    function automatic logic [22:0] sel(input logic [1:0] pcs,
                                        input logic [1:0] asb,
                                        input logic [3:0] alu);
        logic [22:0] w;
        w        = '0;
        w[19:18] = pcs;
        w[9:8]   = asb;
        w[6:3]   = alu;
        return w;
    endfunction

    logic [22:0] E_RST, E_FW, E_FR, E_DEC, E_MADR, E_MRD, E_MWB, E_MWW, E_MWR;
    logic [22:0] E_RWB, E_IWB, E_JMP, E_ILL;

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [22:0] exp_ctl;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add_vec(input logic r, input logic [5:0] op,
                           input logic [5:0] fn, input logic rdy,
                           input logic [3:0] st, input logic [22:0] e);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.funct = fn; v.mem_ready = rdy;
        v.exp_state = st; v.exp_ctl = e;
        vecs.push_back(v);
    endtask

    // Fetch completing at once, then decode
    task automatic add_fd(input logic [5:0] op, input logic [5:0] fn);
        add_vec(1'b1, op, fn, 1'b1, 4'd0, E_FR);
        add_vec(1'b1, op, fn, 1'b0, 4'd1, E_DEC);
    endtask

    task automatic check(input string name, input logic [3:0] es,
                         input logic [22:0] ec);
        checks++;
        if (state !== es) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", name, state, es);
        end
        checks++;
        if (act_ctl !== ec) begin
            errors++;
            $display("FAIL %s ctl: got %h expected %h", name, act_ctl, ec);
        end
    endtask

    // Drive inputs for one cycle, compare mid-cycle, advance past the edge
    task automatic cyc(input string name, input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy,
                       input logic [3:0] es, input logic [22:0] ec);
        rst_n = r; opcode = op; funct = fn; mem_ready = rdy;
        @(negedge clk);
        check(name, es, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        E_RST  = sel(2'b00, 2'b01, A_ADD);
        E_FW   = MR | sel(2'b00, 2'b01, A_ADD);
        E_FR   = E_FW | IRW | PCW;
        E_DEC  = sel(2'b00, 2'b11, A_ADD);
        E_MADR = ASA | sel(2'b00, 2'b10, A_ADD);
        E_MRD  = IORD | MR | sel(2'b00, 2'b00, A_ADD);
        E_MWB  = RW | M2R | DONE | sel(2'b00, 2'b00, A_ADD);
        E_MWW  = IORD | MW | sel(2'b00, 2'b00, A_ADD);
        E_MWR  = E_MWW | DONE;
        E_RWB  = RW | RDST | DONE | sel(2'b00, 2'b00, A_ADD);
        E_IWB  = RW | DONE | sel(2'b00, 2'b00, A_ADD);
        E_JMP  = PCW | DONE | sel(2'b10, 2'b00, A_ADD);
        E_ILL  = ILL | sel(2'b00, 2'b00, A_ADD);

        // add $3,$1,$2 : 0,1,6,7
        add_fd(6'd0, 6'd32);
        add_vec(1, 6'd0, 6'd32, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_ADD));
        add_vec(1, 6'd0, 6'd32, 0, 4'd7, E_RWB);
        // sub, slt, and, or R-types
        add_fd(6'd0, 6'd34);
        add_vec(1, 6'd0, 6'd34, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_SUB));
        add_vec(1, 6'd0, 6'd34, 0, 4'd7, E_RWB);
        add_fd(6'd0, 6'd42);
        add_vec(1, 6'd0, 6'd42, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_SLT));
        add_vec(1, 6'd0, 6'd42, 0, 4'd7, E_RWB);
        add_fd(6'd0, 6'd36);
        add_vec(1, 6'd0, 6'd36, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_AND));
        add_vec(1, 6'd0, 6'd36, 0, 4'd7, E_RWB);
        add_fd(6'd0, 6'd37);
        add_vec(1, 6'd0, 6'd37, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_OR));
        add_vec(1, 6'd0, 6'd37, 0, 4'd7, E_RWB);
        // lw 0x8C220020 with two MEMRD wait cycles: 0,1,2,3,3,3,4
        add_fd(6'd35, 6'd32);
        add_vec(1, 6'd35, 6'd32, 0, 4'd2, E_MADR);
        add_vec(1, 6'd35, 6'd32, 0, 4'd3, E_MRD);
        add_vec(1, 6'd35, 6'd32, 0, 4'd3, E_MRD);
        add_vec(1, 6'd35, 6'd32, 1, 4'd3, E_MRD);
        add_vec(1, 6'd35, 6'd32, 0, 4'd4, E_MWB);
        // beq, bne, j 0x08002710
        add_fd(6'd4, 6'd0);
        add_vec(1, 6'd4, 6'd0, 0, 4'd10, ASA | DONE | BEQ | sel(2'b01, 2'b00, A_SUB));
        add_fd(6'd5, 6'd0);
        add_vec(1, 6'd5, 6'd0, 0, 4'd10, ASA | DONE | BNE | sel(2'b01, 2'b00, A_SUB));
        add_fd(6'd2, 6'd16);
        add_vec(1, 6'd2, 6'd16, 0, 4'd11, E_JMP);
        // illegal opcode, then illegal R-type funct
        add_fd(6'd63, 6'd0);
        add_vec(1, 6'd63, 6'd0, 0, 4'd12, E_ILL);
        add_fd(6'd0, 6'd0);
        add_vec(1, 6'd0, 6'd0, 0, 4'd12, E_ILL);
        // sw with one MEMWR wait cycle
        add_fd(6'd43, 6'd0);
        add_vec(1, 6'd43, 6'd0, 0, 4'd2, E_MADR);
        add_vec(1, 6'd43, 6'd0, 0, 4'd5, E_MWW);
        add_vec(1, 6'd43, 6'd0, 1, 4'd5, E_MWR);
        // I-types: addi, andi, ori, slti
        add_fd(6'd8, 6'd0);
        add_vec(1, 6'd8, 6'd0, 0, 4'd8, ASA | sel(2'b00, 2'b10, A_ADD));
        add_vec(1, 6'd8, 6'd0, 0, 4'd9, E_IWB);
        add_fd(6'd12, 6'd0);
        add_vec(1, 6'd12, 6'd0, 0, 4'd8, ASA | ZEXT | sel(2'b00, 2'b10, A_AND));
        add_vec(1, 6'd12, 6'd0, 0, 4'd9, E_IWB);
        add_fd(6'd13, 6'd0);
        add_vec(1, 6'd13, 6'd0, 0, 4'd8, ASA | ZEXT | sel(2'b00, 2'b10, A_OR));
        add_vec(1, 6'd13, 6'd0, 0, 4'd9, E_IWB);
        add_fd(6'd10, 6'd0);
        add_vec(1, 6'd10, 6'd0, 0, 4'd8, ASA | sel(2'b00, 2'b10, A_SLT));
        add_vec(1, 6'd10, 6'd0, 0, 4'd9, E_IWB);

        // Power-up reset
        rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, 6'd0, 6'd0, 0, 4'd0, E_RST);

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].opcode,
                vecs[i].funct, vecs[i].mem_ready, vecs[i].exp_state,
                vecs[i].exp_ctl);
        end

        // Reset in the middle of a store: write strobe drops in the reset cycle
        cyc("rst_sw_f", 1, 6'd43, 6'd0, 1, 4'd0, E_FR);
        cyc("rst_sw_d", 1, 6'd43, 6'd0, 0, 4'd1, E_DEC);
        cyc("rst_sw_a", 1, 6'd43, 6'd0, 0, 4'd2, E_MADR);
        cyc("rst_sw_w", 1, 6'd43, 6'd0, 0, 4'd5, E_MWW);
        cyc("rst_mid1", 0, 6'd43, 6'd0, 1, 4'd5, IORD | sel(2'b00, 2'b00, A_ADD));
        cyc("rst_mid2", 0, 6'd43, 6'd0, 1, 4'd0, E_RST);

        // Fetch timeout: bus_error in the 3rd wait cycle, then retry
        cyc("to_w1", 1, 6'd0, 6'd32, 0, 4'd0, E_FW);
        cyc("to_w2", 1, 6'd0, 6'd32, 0, 4'd0, E_FW);
        cyc("to_w3", 1, 6'd0, 6'd32, 0, 4'd0, E_FW | BERR);
        cyc("to_re1", 1, 6'd0, 6'd32, 0, 4'd0, E_FW);
        cyc("to_re2", 1, 6'd0, 6'd32, 0, 4'd0, E_FW);
        // mem_ready exactly in the limit cycle completes normally
        cyc("lim_rdy", 1, 6'd0, 6'd32, 1, 4'd0, E_FR);
        cyc("lim_dec", 1, 6'd0, 6'd32, 0, 4'd1, E_DEC);
        cyc("lim_ex", 1, 6'd0, 6'd32, 0, 4'd6, ASA | sel(2'b00, 2'b00, A_ADD));
        cyc("lim_wb", 1, 6'd0, 6'd32, 0, 4'd7, E_RWB);
        cyc("lim_end", 1, 6'd0, 6'd32, 0, 4'd0, E_FW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
